lcd_ctrl: RTL



---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_if.sv | 11 +
 rtl/lcd_timer.sv | 26 ++
 rtl/lcd_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write sequencer. This file holds the FSM states,
// the power-on init command table, the pin packing and the clear/home classification.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRON,
    LOAD,
    SETUP,
    EN_HI,
    HOLD,
    WAIT,
    IDLE
  } state_t;

  localparam int INIT_COUNT = 4;

  localparam int LCD_DATA_LSB = 0;
  localparam int LCD_RW_BIT   = 8;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_EN_BIT   = 10;
  localparam int LCD_ON_BIT   = 31;

  // Init sequence: 8-bit/2-line, display on, clear, entry mode increment.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data inside {8'h01, 8'h02, 8'h03});
  endfunction

endpackage

// File: rtl/lcd_if.sv
// Processor-side valid/ready write port of the LCD sequencer. The member names
// mirror the controller's pin names.
interface lcd_if;
  logic       i_valid;
  logic       i_rs;
  logic [7:0] i_data;
  logic       o_ready;

  modport master (output i_valid, i_rs, i_data, input o_ready);
  modport slave  (input i_valid, i_rs, i_data, output o_ready);
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter. A phase of N cycles is obtained by loading N-1, and the phase
// ends in the cycle where o_done is high.
module lcd_timer #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RST_COUNT = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_count,
  output logic         o_done
);

  logic [W-1:0] cnt;

  // NOTE: clocked state uses non-blocking assignments only; blocking here would race
  // against every other always_ff reading cnt on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         cnt <= RST_COUNT;
    else if (i_load)      cnt <= i_count;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign o_done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer. It runs the power-on init and then accepts byte writes,
// generating RS/RW/EN/DATA timing and packing the pins into o_io_lcd.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 3,
  parameter int EN_CYC    = 25,
  parameter int HOLD_CYC  = 3,
  parameter int SHORT_CYC = 2_000,
  parameter int LONG_CYC  = 100_000,
  parameter int PWRON_CYC = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  lcd_if.slave        bus,
  output logic        o_init_done,
  output logic [31:0] o_io_lcd
);

  localparam int MAX_A   = (SETUP_CYC > EN_CYC)   ? SETUP_CYC : EN_CYC;
  localparam int MAX_B   = (HOLD_CYC  > SHORT_CYC) ? HOLD_CYC  : SHORT_CYC;
  localparam int MAX_C   = (LONG_CYC  > PWRON_CYC) ? LONG_CYC  : PWRON_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] EN_LD    = TW'(EN_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] SHORT_LD = TW'(SHORT_CYC - 1);
  localparam logic [TW-1:0] LONG_LD  = TW'(LONG_CYC - 1);
  localparam logic [TW-1:0] PWRON_LD = TW'(PWRON_CYC - 1);

  state_t          state, next_state;
  logic [2:0]      idx;
  logic            rs_q, en_q, on_q, ready_q, init_done_q;
  logic [7:0]      data_q;
  logic            tmr_load, tmr_done;
  logic [TW-1:0]   tmr_count;
  logic            load_step, take_rom, take_req, finish_init;

  lcd_timer #(.W(TW), .RST_COUNT(PWRON_LD)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (tmr_load),
    .i_count (tmr_count),
    .o_done  (tmr_done)
  );

  // The LOAD decision is resolved on the exit edge of PWRON/WAIT so that it adds no cycle.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state  = state;
    tmr_load    = 1'b0;
    tmr_count   = SETUP_LD;
    load_step   = 1'b0;
    take_rom    = 1'b0;
    take_req    = 1'b0;
    finish_init = 1'b0;
    case (state)
      PWRON: load_step = tmr_done;
      LOAD:  load_step = 1'b1;
      SETUP: if (tmr_done) begin
        next_state = EN_HI;
        tmr_load   = 1'b1;
        tmr_count  = EN_LD;
      end
      EN_HI: if (tmr_done) begin
        next_state = HOLD;
        tmr_load   = 1'b1;
        tmr_count  = HOLD_LD;
      end
      HOLD: if (tmr_done) begin
        next_state = WAIT;
        tmr_load   = 1'b1;
        tmr_count  = is_long_cmd(rs_q, data_q) ? LONG_LD : SHORT_LD;
      end
      WAIT: if (tmr_done) begin
        if (!init_done_q) load_step  = 1'b1;
        else              next_state = IDLE;
      end
      IDLE: if (bus.i_valid) begin
        next_state = SETUP;
        tmr_load   = 1'b1;
        take_req   = 1'b1;
      end
      default: next_state = PWRON;
    endcase

    if (load_step) begin
      if (idx < 3'(INIT_COUNT)) begin
        next_state = SETUP;
        tmr_load   = 1'b1;
        tmr_count  = SETUP_LD;
        take_rom   = 1'b1;
      end else begin
        next_state  = IDLE;
        finish_init = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= PWRON;
      idx         <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state   <= next_state;
      on_q    <= 1'b1;
      en_q    <= (next_state == EN_HI);
      ready_q <= (next_state == IDLE);
      if (finish_init) init_done_q <= 1'b1;
      if (take_rom) begin
        rs_q   <= 1'b0;
        data_q <= init_cmd(idx[1:0]);
        idx    <= idx + 3'd1;
      end
      if (take_req) begin
        rs_q   <= bus.i_rs;
        data_q <= bus.i_data;
      end
    end
  end

  assign bus.o_ready = ready_q;
  assign o_init_done = init_done_q;

  always_comb begin
    o_io_lcd                              = '0;
    o_io_lcd[LCD_DATA_LSB +: 8]           = data_q;
    o_io_lcd[LCD_RW_BIT]                  = 1'b0;
    o_io_lcd[LCD_RS_BIT]                  = rs_q;
    o_io_lcd[LCD_EN_BIT]                  = en_q;
    o_io_lcd[LCD_ON_BIT]                  = on_q;
  end

endmodule
